// File: rtl/tile_pos_write_ctrl.sv
// Write scheduler for the tile-position table: post-reset clear, CPU/scroll arbitration,
// circular head pointer. Define WRITE_POS_RR_EN for round-robin arbitration (default: scroll priority).
module tile_pos_write_ctrl #(
    parameter int ROWS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_row,
    input  logic [2:0]        cpu_data,
    output logic              cpu_ack,
    input  logic              scr_req,
    input  logic [1:0]        scr_col,
    output logic              scr_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic [ADDR_W-1:0] head,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Handshake: a requester raises req with stable payload and holds it until it sees
    // its one-cycle ack; dropping req before ack cancels. Payload is sampled once, at grant.

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_data_q, wr_data_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              scr_ack_q, scr_ack_d;
    logic              busy_q, busy_d;
    logic              grant_scr;
    logic              grant_cpu;
    logic [ADDR_W-1:0] head_dec;

`ifdef WRITE_POS_RR_EN
    // 1 = scroll was served last, 0 = CPU
    logic              last_grant_q, last_grant_d;
`endif

    assign head_dec = head_q - ADDR_W'(1);

    always_comb begin
        grant_scr = 1'b0;
        grant_cpu = 1'b0;
`ifdef WRITE_POS_RR_EN
        if (scr_req && cpu_req) begin
            grant_scr = ~last_grant_q;
            grant_cpu = last_grant_q;
        end else begin
            grant_scr = scr_req;
            grant_cpu = cpu_req;
        end
`else
        grant_scr = scr_req;
        grant_cpu = cpu_req & ~scr_req;
`endif
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        head_d    = head_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cpu_ack_d = 1'b0;
        scr_ack_d = 1'b0;
        busy_d    = busy_q;
`ifdef WRITE_POS_RR_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = 3'b000;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_IDLE: begin
                if (grant_scr) begin
                    // Scrolling moves the head up one row and writes the new top row there.
                    head_d    = head_dec;
                    wr_en_d   = 1'b1;
                    wr_addr_d = head_dec;
                    wr_data_d = {1'b1, scr_col};
                    scr_ack_d = 1'b1;
                    state_d   = ST_WRITE;
                end else if (grant_cpu) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = head_q + cpu_row;
                    wr_data_d = cpu_data;
                    cpu_ack_d = 1'b1;
                    state_d   = ST_WRITE;
                end
            end

            ST_WRITE: begin
`ifdef WRITE_POS_RR_EN
                last_grant_d = scr_ack_q;
`endif
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            head_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 3'b000;
            cpu_ack_q <= 1'b0;
            scr_ack_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef WRITE_POS_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            head_q    <= head_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_ack_q <= cpu_ack_d;
            scr_ack_q <= scr_ack_d;
            busy_q    <= busy_d;
`ifdef WRITE_POS_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign scr_ack   = scr_ack_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign head      = head_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_pos_write_ctrl.sv
// Bench for tile_pos_write_ctrl: directed cases with literal expectations plus a randomized
// run compared every cycle against a transaction-level model of the table writer.
module tb_tile_pos_write_ctrl;
    localparam int ROWS = 8;
    localparam int AW   = 3;
`ifdef WRITE_POS_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          PCLK     = 1'b0;
    logic          PRESERN  = 1'b0;
    logic          cpu_req  = 1'b0;
    logic [AW-1:0] cpu_row  = '0;
    logic [2:0]    cpu_data = 3'b000;
    logic          scr_req  = 1'b0;
    logic [1:0]    scr_col  = 2'b00;
    logic          cpu_ack, scr_ack, wr_en, busy;
    logic [AW-1:0] wr_addr, head;
    logic [2:0]    wr_data;
    logic [1:0]    dbg_state;

    tile_pos_write_ctrl #(.ROWS(ROWS), .ADDR_W(AW)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN),
        .cpu_req(cpu_req), .cpu_row(cpu_row), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .scr_req(scr_req), .scr_col(scr_col), .scr_ack(scr_ack),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .head(head), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Edges since reset release; the first ROWS edges write zeros to rows 0..ROWS-1,
    // afterwards each grant is followed by one edge on which nothing is granted.
    int m_cyc, m_head, m_hold;
    bit m_last_scr;
    int m_mem[ROWS];
    int d_mem[ROWS];
    int exp_wr_en, exp_addr, exp_data, exp_cack, exp_sack, exp_busy;

    task automatic m_reset();
        m_cyc = 0; m_head = 0; m_hold = -1; m_last_scr = 1'b0;
        exp_wr_en = 0; exp_addr = 0; exp_data = 0; exp_cack = 0; exp_sack = 0; exp_busy = 1;
    endtask

    task automatic m_step();
        bit take_scr;
        m_cyc++;
        exp_wr_en = 0; exp_cack = 0; exp_sack = 0;
        if (m_cyc <= ROWS) begin
            exp_wr_en = 1; exp_addr = m_cyc - 1; exp_data = 0;
            m_mem[exp_addr] = 0;
            exp_busy = (m_cyc < ROWS) ? 1 : 0;
        end else if (m_cyc != m_hold && (cpu_req || scr_req)) begin
            if (cpu_req && scr_req) take_scr = RR ? !m_last_scr : 1'b1;
            else take_scr = scr_req;
            if (take_scr) begin
                m_head = (m_head + ROWS - 1) % ROWS;
                exp_addr = m_head; exp_data = 4 + int'(scr_col); exp_sack = 1;
            end else begin
                exp_addr = (m_head + int'(cpu_row)) % ROWS; exp_data = int'(cpu_data); exp_cack = 1;
            end
            m_last_scr = take_scr;
            exp_wr_en = 1;
            m_mem[exp_addr] = exp_data;
            m_hold = m_cyc + 1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge PCLK or negedge PRESERN);
            if (!PRESERN) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge PCLK);
            chk("wr_en", wr_en, exp_wr_en);
            chk("cpu_ack", cpu_ack, exp_cack);
            chk("scr_ack", scr_ack, exp_sack);
            chk("head", head, m_head);
            chk("busy", busy, exp_busy);
            if (exp_wr_en != 0) begin
                chk("wr_addr", wr_addr, exp_addr);
                chk("wr_data", wr_data, exp_data);
            end
            if (wr_en === 1'b1) d_mem[wr_addr] = int'(wr_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge PCLK);
        #2 PRESERN = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESERN = 1'b1;
    endtask

    task automatic cpu_write(input int row, input int d, output int n);
        cpu_row = row[AW-1:0]; cpu_data = d[2:0]; cpu_req = 1'b1; n = 0;
        do begin @(negedge PCLK); n++; end while (cpu_ack !== 1'b1 && n < 40);
        chk("cpu_ack_seen", cpu_ack, 1);
        cpu_req = 1'b0;
    endtask

    task automatic scr_write(input int col, output int n);
        scr_col = col[1:0]; scr_req = 1'b1; n = 0;
        do begin @(negedge PCLK); n++; end while (scr_ack !== 1'b1 && n < 40);
        chk("scr_ack_seen", scr_ack, 1);
        scr_req = 1'b0;
    endtask

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, order, s_cnt, c_done;

        @(negedge PCLK);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 1);
        chk("rst_head", head, 0);
        #2 PRESERN = 1'b1;

        // post-reset clear: 8 writes of zero to addresses 0..7
        for (int k = 1; k <= ROWS; k++) begin
            @(negedge PCLK);
            chk("clr_en", wr_en, 1);
            chk("clr_addr", wr_addr, k - 1);
            chk("clr_data", wr_data, 0);
            chk("clr_busy", busy, (k < ROWS) ? 1 : 0);
        end
        @(negedge PCLK);
        chk("post_clr_en", wr_en, 0);
        chk("post_clr_busy", busy, 0);

        cpu_write(2, 5, n);
        chk("cpu_latency", n, 1);
        chk("cpu_addr", wr_addr, 2);
        chk("cpu_data", wr_data, 5);

        scr_write(3, n);
        chk("scr_addr", wr_addr, 7);
        chk("scr_data", wr_data, 7);
        chk("scr_head", head, 7);

        cpu_write(2, 1, n);
        chk("cpu_wrap_addr", wr_addr, 1);

        // request held through the clear is served on cycle 9
        do_reset();
        cpu_write(4, 6, n);
        chk("clear_wait_cycles", n, 9);
        chk("clear_wait_addr", wr_addr, 4);

        // contention: scroll requester re-requests right after its first ack
        scr_col = 2'b10; cpu_row = 3'd1; cpu_data = 3'd3;
        scr_req = 1'b1; cpu_req = 1'b1;
        order = 0; s_cnt = 0; c_done = 0;
        for (int i = 0; i < 30 && !(s_cnt == 2 && c_done == 1); i++) begin
            @(negedge PCLK);
            if (scr_ack === 1'b1) begin
                order = order * 4 + 1; s_cnt++;
                if (s_cnt == 2) scr_req = 1'b0;
            end
            if (cpu_ack === 1'b1) begin
                order = order * 4 + 2; c_done = 1; cpu_req = 1'b0;
            end
        end
        chk("contention_order", order, RR ? 25 : 22);
        scr_req = 1'b0; cpu_req = 1'b0;

        // reset during a WRITE cycle
        cpu_row = 3'd3; cpu_data = 3'd7; cpu_req = 1'b1;
        n = 0;
        do begin @(negedge PCLK); n++; end while (cpu_ack !== 1'b1 && n < 40);
        chk("mid_write_ack_seen", cpu_ack, 1);
        #2 PRESERN = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_ack", cpu_ack, 0);
        chk("mid_rst_head", head, 0);
        chk("mid_rst_busy", busy, 1);
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESERN = 1'b1;
        @(negedge PCLK);
        chk("restart_en", wr_en, 1);
        chk("restart_addr", wr_addr, 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge PCLK);
            if (cpu_req && cpu_ack) cpu_req = 1'b0;
            else if (cpu_req && $urandom_range(0, 15) == 0) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1;
                cpu_row = AW'($urandom_range(0, ROWS - 1));
                cpu_data = 3'($urandom_range(0, 7));
            end
            if (scr_req && scr_ack) scr_req = 1'b0;
            else if (scr_req && $urandom_range(0, 15) == 0) scr_req = 1'b0;
            else if (!scr_req && $urandom_range(0, 3) == 0) begin
                scr_req = 1'b1;
                scr_col = 2'($urandom_range(0, 3));
            end
            if (!PRESERN) #2 PRESERN = 1'b1;
            else if ($urandom_range(0, 699) == 0) #2 PRESERN = 1'b0;
        end
        cpu_req = 1'b0; scr_req = 1'b0;
        @(negedge PCLK);
        #2 PRESERN = 1'b1;
        repeat (20) @(negedge PCLK);

        // logical table contents as seen through each side's head pointer
        for (int r = 0; r < ROWS; r++)
            chk("table_row", d_mem[(int'(head) + r) % ROWS], m_mem[(m_head + r) % ROWS]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_pos_write_ctrl.md
# tile_pos_write_ctrl

Write scheduler for the tile-position table of the game display path. Arbitrates between two write requesters, the CPU/game logic (marks or clears tiles) and the scroll engine (inserts a new top row each scroll step), and issues single-cycle write strobes to the external position table. Maintains a circular head pointer so scrolling costs one write instead of a full table shift, and clears the table after reset.

## Interface
Parameters:
- ROWS, 8, number of table rows; power of two, ≥2
- ADDR_W, 3, log2(ROWS)

Ports:
- PCLK  in  1  system clock; all logic on rising edge
- PRESERN  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU write request; held until cpu_ack
- cpu_row  in  ADDR_W  logical row (0 = top of screen)
- cpu_data  in  3  {valid, col[1:0]}
- cpu_ack  out  1  one-cycle pulse, CPU write performed
- scr_req  in  1  scroll request; held until scr_ack
- scr_col  in  2  column of the new top-row tile
- scr_ack  out  1  one-cycle pulse, scroll performed
- wr_en  out  1  table write strobe
- wr_addr  out  ADDR_W  physical table address
- wr_data  out  3  {valid, col}
- head  out  ADDR_W  physical address of logical row 0
- busy  out  1  high during post-reset clear

## Operation
- FSM states: CLEAR, IDLE, WRITE.
- Reset: state=CLEAR, clr_cnt=0, head=0, wr_en=0, wr_addr=0, wr_data=0, cpu_ack=0, scr_ack=0, busy=1, last_grant=CPU.
- CLEAR: each cycle wr_en=1, wr_addr=clr_cnt, wr_data=0; clr_cnt increments; after writing address ROWS-1 go to IDLE, busy=0. Requests ignored (no ack) during CLEAR.
- IDLE: if neither req, stay. Otherwise pick winner (see Configuration), register address/data, go to WRITE.
  - Scroll grant: head_next = head-1 mod ROWS; wr_addr=head_next; wr_data={1,scr_col}; head updates to head_next on entry to WRITE.
  - CPU grant: wr_addr=(head + cpu_row) mod ROWS using head at grant cycle; wr_data=cpu_data.
- WRITE: wr_en=1 for exactly one cycle, winner's ack=1 same cycle, last_grant updated; return to IDLE.
- Arithmetic: ADDR_W-bit modular add/sub, natural wrap (ROWS power of two).
- Payload sampled only in the IDLE grant cycle; requester changes after that are ignored. Deasserting req before ack while in IDLE cancels cleanly (nothing written).
- Loser's req stays pending and is served on the next IDLE evaluation.

## Timing
- Request seen in IDLE at edge N → wr_en and ack high during cycle N+1 → IDLE at N+2.
- Max throughput: one write per 2 cycles; both requesters pending → served back-to-back, 4 cycles total.
- head visible updated in the same cycle as scroll wr_en.
- Clear: busy high for exactly ROWS cycles after PRESERN release; first request accepted in cycle ROWS.
- PRESERN low at any time (including WRITE or mid-CLEAR): all outputs to reset values immediately, in-flight write dropped without ack, clear restarts from address 0.
- wr_en, ack, wr_addr, wr_data are registered; no combinational input→output paths.

## Configuration
- WRITE_POS_RR_EN defined: round-robin on simultaneous requests; winner is the requester opposite last_grant (first contention after reset → scroll).
- Not defined: fixed priority, scroll always wins simultaneous requests; last_grant register omitted. CPU starvation prevented only by the 2-cycle WRITE gap being used by the CPU when scr_req is low.

## Test plan
- Reset release, no requests → wr_en high 8 cycles, addr 0..7, data 0, busy falls after cycle 8, head=0.
- After clear, cpu_req row=2 data=3'b101 → cycle+1: wr_en=1, wr_addr=2, wr_data=5, cpu_ack=1 one cycle.
- Scroll with head=0, scr_col=3 → wr_addr=7, wr_data=3'b111, head=7, scr_ack pulse; then CPU row=2 → wr_addr=1 (wrap).
- Simultaneous cpu_req+scr_req twice in a row: RR_EN → scroll, CPU, then CPU-before-scroll alternation checked; without macro → scroll both times first.
- cpu_req asserted during CLEAR → no ack until busy=0, then served at cycle 9.
- PRESERN pulsed low during WRITE → no ack, wr_en=0 immediately, head=0, clear restarts at address 0.
